// File: rtl/ex_stage.sv
// ex_stage: execute stage between ID/EX and EX/MEM.
//   Single-cycle ALU ops register their result on the next negedge.
//   Multiply (R-type, func == MUL_FUNC) runs an iterative shift-add over
//   WIDTH edges while out_hit holds the front end.
// Ports:
//   inp_clk / inp_rst_n      clock (state on negedge) / async active-low reset
//   inp_valid, inp_func, inp_aluOp, inp_aluSrc, inp_regDst   decoded instruction
//   inp_data1/2, inp_immdate operands A / store data / immediate
//   inp_rt, inp_rd           destination candidates
//   inp_regWrite..memToReg   MEM/WB control passthrough
//   out_hit                  upstream may advance this cycle (combinational)
//   out_valid, out_result, out_storeData, out_wreg, out_zero, out_* control
//                            registered EX/MEM payload
module ex_stage #(
  parameter int         WIDTH    = 16,
  parameter logic [3:0] MUL_FUNC = 4'hA
) (
  input  logic             inp_clk,
  input  logic             inp_rst_n,
  input  logic             inp_valid,
  input  logic [3:0]       inp_func,
  input  logic [2:0]       inp_aluOp,
  input  logic             inp_aluSrc,
  input  logic             inp_regDst,
  input  logic [WIDTH-1:0] inp_data1,
  input  logic [WIDTH-1:0] inp_data2,
  input  logic [WIDTH-1:0] inp_immdate,
  input  logic [2:0]       inp_rt,
  input  logic [2:0]       inp_rd,
  input  logic             inp_regWrite,
  input  logic             inp_memRead,
  input  logic             inp_memWrite,
  input  logic             inp_memToReg,
  output logic             out_hit,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_result,
  output logic [WIDTH-1:0] out_storeData,
  output logic [2:0]       out_wreg,
  output logic             out_zero,
  output logic             out_regWrite,
  output logic             out_memRead,
  output logic             out_memWrite,
  output logic             out_memToReg
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d, sdata_q, sdata_d;
  logic [2:0]       wreg_q, wreg_d;
  logic             zero_q, zero_d, vld_q, vld_d;
  logic [3:0]       ctl_q, ctl_d;          // {regWrite, memRead, memWrite, memToReg}
  // multiply working set plus the held instruction's EX/MEM payload
  logic [WIDTH-1:0] ma_q, ma_d, mb_q, mb_d, prod_q, prod_d, hsd_q, hsd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       hwreg_q, hwreg_d;
  logic [3:0]       hctl_q, hctl_d;

  logic [WIDTH-1:0] op_b, alu_res;
  logic [3:0]       in_ctl;
  logic [2:0]       in_wreg;
  logic             is_mul, mul_start;

  assign op_b      = inp_aluSrc ? inp_immdate : inp_data2;
  assign is_mul    = (inp_aluOp == 3'b010) && (inp_func == MUL_FUNC);
  assign mul_start = (state_q == IDLE) && inp_valid && is_mul;
  assign in_ctl    = {inp_regWrite, inp_memRead, inp_memWrite, inp_memToReg};
  assign in_wreg   = inp_regDst ? inp_rd : inp_rt;

  always_comb begin
    alu_res = '0;
    case (inp_aluOp)
      3'b001: alu_res = inp_data1 - op_b;
      3'b011: alu_res = inp_data1 & op_b;
      3'b100: alu_res = inp_data1 | op_b;
      3'b010: begin
        case (inp_func)
          4'd0: alu_res = inp_data1 + op_b;
          4'd1: alu_res = inp_data1 - op_b;
          4'd2: alu_res = inp_data1 & op_b;
          4'd3: alu_res = inp_data1 | op_b;
          4'd4: alu_res = inp_data1 ^ op_b;
          4'd5: alu_res = ~(inp_data1 | op_b);
          4'd6: alu_res = {{(WIDTH-1){1'b0}}, ($signed(inp_data1) < $signed(op_b))};
          4'd7: alu_res = inp_data1 << op_b[3:0];
          4'd8: alu_res = inp_data1 >> op_b[3:0];
          4'd9: alu_res = WIDTH'($signed(inp_data1) >>> op_b[3:0]);
          default: alu_res = '0;  // multiply handled by the FSM path
        endcase
      end
      default: alu_res = inp_data1 + op_b;
    endcase
  end

  // state register (all flops update on the falling edge)
  always_ff @(negedge inp_clk or negedge inp_rst_n) begin
    if (!inp_rst_n) begin
      state_q <= IDLE;
      res_q   <= '0;  sdata_q <= '0;  wreg_q  <= '0;  zero_q <= 1'b0;
      vld_q   <= 1'b0; ctl_q  <= '0;
      ma_q    <= '0;  mb_q    <= '0;  prod_q  <= '0;  cnt_q  <= '0;
      hsd_q   <= '0;  hwreg_q <= '0;  hctl_q  <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;   sdata_q <= sdata_d; wreg_q  <= wreg_d;  zero_q <= zero_d;
      vld_q   <= vld_d;   ctl_q   <= ctl_d;
      ma_q    <= ma_d;    mb_q    <= mb_d;    prod_q  <= prod_d;  cnt_q  <= cnt_d;
      hsd_q   <= hsd_d;   hwreg_q <= hwreg_d; hctl_q  <= hctl_d;
    end
  end

  // next-state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mul_start) state_d = MUL;
      MUL:     if (cnt_q == CW'(WIDTH-1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // outputs / datapath
  always_comb begin
    out_hit = 1'b0;
    // default: register a bubble, hold multiply state
    res_d   = '0;  sdata_d = '0;  wreg_d = '0;  vld_d = 1'b0;  ctl_d = '0;
    ma_d    = ma_q;  mb_d = mb_q;  prod_d = prod_q;  cnt_d = cnt_q;
    hsd_d   = hsd_q; hwreg_d = hwreg_q; hctl_d = hctl_q;
    case (state_q)
      IDLE: begin
        if (mul_start) begin
          ma_d    = inp_data1;
          mb_d    = op_b;
          prod_d  = '0;
          cnt_d   = '0;
          hsd_d   = inp_data2;
          hwreg_d = in_wreg;
          hctl_d  = in_ctl;
        end else begin
          out_hit = 1'b1;
          res_d   = alu_res;
          sdata_d = inp_data2;
          wreg_d  = in_wreg;
          vld_d   = inp_valid;
          ctl_d   = in_ctl & {4{inp_valid}};
        end
      end
      MUL: begin
        if (mb_q[0]) prod_d = prod_q + ma_q;
        ma_d  = ma_q << 1;
        mb_d  = mb_q >> 1;
        cnt_d = cnt_q + 1'b1;
      end
      DONE: begin
        out_hit = 1'b1;
        res_d   = prod_q;
        sdata_d = hsd_q;
        wreg_d  = hwreg_q;
        vld_d   = 1'b1;
        ctl_d   = hctl_q;
      end
      default: ;
    endcase
    zero_d  = (res_d == '0);
    out_hit = out_hit & inp_rst_n;  // front end must not advance while in reset
  end

  assign out_valid     = vld_q;
  assign out_result    = res_q;
  assign out_storeData = sdata_q;
  assign out_wreg      = wreg_q;
  assign out_zero      = zero_q;
  assign {out_regWrite, out_memRead, out_memWrite, out_memToReg} = ctl_q;
endmodule
